// File: rtl/sd_reg_pkg.sv
// ---------------------------------------------------------------------------
// sd_reg_pkg
// Shared definitions for the SD host register-set bridge:
//   - register-set request size codes (SZ_NONE/SZ_BYTE/SZ_HALF/SZ_WORD)
//   - bridge_state_t, the bridge FSM state encoding
//   - access_legal(), the size/alignment check applied to host requests
// ---------------------------------------------------------------------------
package sd_reg_pkg;

  localparam logic [1:0] SZ_NONE = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  localparam logic [1:0] SZ_WORD = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } bridge_state_t;

  // Natural alignment keeps address+1..+3 inside the same aligned word, so a
  // legal access can never wrap past the top of the register-set space.
  function automatic logic access_legal(input logic [1:0] size,
                                        input logic [1:0] addr_lsb);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = (addr_lsb[0] == 1'b0);
      SZ_WORD: ok = (addr_lsb == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sd_reg_timeout.sv
// ---------------------------------------------------------------------------
// sd_reg_timeout
// WAIT-phase watchdog counter used by sd_reg_bridge when REG_BRIDGE_TIMEOUT_EN
// is defined.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-low reset
//   load     in   clear the count (has priority over enable)
//   enable   in   count one cycle
//   expired  out  count has reached TIMEOUT_CYCLES-1, i.e. the current
//                 counted cycle is the TIMEOUT_CYCLES-th one
// ---------------------------------------------------------------------------
module sd_reg_timeout #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);

  // One spare bit keeps the width at least 2 even for tiny timeouts.
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1) + 1;

  logic [CW-1:0] count_r;

  assign expired = (count_r == CW'(TIMEOUT_CYCLES - 1));

  // Cycle counter: cleared by load, saturates once expired.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {CW{1'b0}};
    end else if (load) begin
      count_r <= {CW{1'b0}};
    end else if (enable && !expired) begin
      count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/sd_reg_bridge.sv
// ---------------------------------------------------------------------------
// sd_reg_bridge
// Converts host valid/ready transactions into single-cycle register-set
// requests, waits for ack and returns read data / error status to the host.
// Optional feature macro: REG_BRIDGE_TIMEOUT_EN (WAIT-phase timeout).
// Ports:
//   clk, reset                 clock / asynchronous active-low reset
//   host_valid/host_ready      request handshake (ready only in IDLE)
//   host_wnr/size/addr/wdata   request fields (size 1=B, 2=half, 3=word)
//   rsp_valid/rsp_ready        response handshake, response held until ready
//   rsp_rdata/rsp_err          read data (upper bytes zero) / error flag
//   req/wnr/address/data_in    register-set request, req one cycle wide
//   ack/data_out               register-set ack and read data
// All outputs are registered.
// ---------------------------------------------------------------------------
module sd_reg_bridge
  import sd_reg_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    host_valid,
  output logic                    host_ready,
  input  logic                    host_wnr,
  input  logic [1:0]              host_size,
  input  logic [ADDR_WIDTH-1:0]   host_addr,
  input  logic [4*DATA_WIDTH-1:0] host_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [4*DATA_WIDTH-1:0] rsp_rdata,
  output logic                    rsp_err,
  output logic [1:0]              req,
  output logic                    wnr,
  output logic [ADDR_WIDTH-1:0]   address,
  output logic [4*DATA_WIDTH-1:0] data_in,
  input  logic                    ack,
  input  logic [4*DATA_WIDTH-1:0] data_out
);

  localparam int BUS_W = 4 * DATA_WIDTH;

  bridge_state_t state_r;
  logic [1:0]    size_r;
  logic          timeout_hit_s;

  // Keep only the bytes covered by the access size.
  function automatic logic [BUS_W-1:0] size_mask(input logic [1:0] size,
                                                 input logic [BUS_W-1:0] data);
    logic [BUS_W-1:0] m;
    case (size)
      SZ_BYTE: m = {{(3*DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};
      SZ_HALF: m = {{(2*DATA_WIDTH){1'b0}}, {(2*DATA_WIDTH){1'b1}}};
      SZ_WORD: m = {BUS_W{1'b1}};
      default: m = {BUS_W{1'b0}};
    endcase
    return data & m;
  endfunction

`ifdef REG_BRIDGE_TIMEOUT_EN
  logic tmo_load_s;
  logic tmo_enable_s;
  logic tmo_expired_s;

  assign tmo_load_s   = (state_r != WAIT);
  assign tmo_enable_s = (state_r == WAIT);

  sd_reg_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .load    (tmo_load_s),
    .enable  (tmo_enable_s),
    .expired (tmo_expired_s)
  );

  assign timeout_hit_s = tmo_expired_s;
`else
  // Without the watchdog WAIT never gives up; the parameter has no effect.
  logic unused_tmo_s;
  assign unused_tmo_s  = ^TIMEOUT_CYCLES;
  assign timeout_hit_s = 1'b0;
`endif

  // Bridge FSM and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      size_r     <= SZ_NONE;
      host_ready <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= {BUS_W{1'b0}};
      rsp_err    <= 1'b0;
      req        <= SZ_NONE;
      wnr        <= 1'b0;
      address    <= {ADDR_WIDTH{1'b0}};
      data_in    <= {BUS_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (host_valid) begin
            host_ready <= 1'b0;
            if (access_legal(host_size, host_addr[1:0])) begin
              // req goes high together with the ISSUE state, so it is
              // visible for exactly the one cycle spent in ISSUE.
              state_r <= ISSUE;
              size_r  <= host_size;
              req     <= host_size;
              wnr     <= host_wnr;
              address <= host_addr;
              data_in <= host_wdata;
            end else begin
              // Rejected without touching the register set.
              state_r   <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= {BUS_W{1'b0}};
            end
          end
        end
        ISSUE: begin
          req     <= SZ_NONE;
          state_r <= WAIT;
        end
        WAIT: begin
          // An ack arriving on the expiry cycle still completes normally.
          if (ack) begin
            state_r   <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= wnr ? {BUS_W{1'b0}} : size_mask(size_r, data_out);
          end else if (timeout_hit_s) begin
            state_r   <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= {BUS_W{1'b0}};
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_r    <= IDLE;
            rsp_valid  <= 1'b0;
            host_ready <= 1'b1;
          end
        end
        default: begin
          state_r    <= IDLE;
          host_ready <= 1'b1;
          rsp_valid  <= 1'b0;
          req        <= SZ_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_reg_bridge.sv
// ---------------------------------------------------------------------------
// tb_sd_reg_bridge
// Self-checking bench for sd_reg_bridge. A byte-array model of the register
// space predicts host-visible results; a separate byte array acts as the
// register set, driven only by the bridge's req/address/data_in outputs.
// ---------------------------------------------------------------------------
module tb_sd_reg_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic        host_wnr = 1'b0;
  logic [1:0]  host_size = 2'd0;
  logic [7:0]  host_addr = 8'd0;
  logic [31:0] host_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  req;
  logic        wnr;
  logic [7:0]  address;
  logic [31:0] data_in;
  logic        ack = 1'b0;
  logic [31:0] data_out = 32'd0;

  logic [7:0] exp_mem [256];
  logic [7:0] rs_mem  [256];

  int n_tests = 0;
  int n_fail  = 0;

  sd_reg_bridge #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .host_valid(host_valid), .host_ready(host_ready), .host_wnr(host_wnr),
    .host_size(host_size), .host_addr(host_addr), .host_wdata(host_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .req(req), .wnr(wnr), .address(address),
    .data_in(data_in), .ack(ack), .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input int size, input int addr);
    if (size == 1) return 1'b1;
    if (size == 2) return (addr % 2) == 0;
    if (size == 3) return (addr % 4) == 0;
    return 1'b0;
  endfunction

  function automatic int nbytes(input int size);
    return (size == 3) ? 4 : size;
  endfunction

  function automatic logic [31:0] model_read(input int size, input int addr);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < nbytes(size); i++) v[8*i +: 8] = exp_mem[(addr + i) % 256];
    return v;
  endfunction

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_host_ready"}, host_ready, 32'd1);
    check_eq({tag, "_rsp_valid"}, rsp_valid, 32'd0);
    check_eq({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check_eq({tag, "_rsp_err"}, rsp_err, 32'd0);
    check_eq({tag, "_req"}, req, 32'd0);
    check_eq({tag, "_wnr"}, wnr, 32'd0);
    check_eq({tag, "_address"}, address, 32'd0);
    check_eq({tag, "_data_in"}, data_in, 32'd0);
  endtask

  // One host transaction, called at a negedge with the bridge idle. The bench
  // plays the register set: it sees req during the cycle after accept and
  // raises ack for the following cycle.
  task automatic do_txn(input logic wr, input logic [1:0] sz, input logic [7:0] ad,
                        input logic [31:0] wd, input int hold, output logic [31:0] got);
    bit          ok;
    logic [31:0] exp_rd;
    logic [31:0] exp_err;
    logic [1:0]  seen_req;
    ok = legal(int'(sz), int'(ad));
    check_eq("host_ready_idle", host_ready, 32'd1);
    host_valid = 1'b1; host_wnr = wr; host_size = sz; host_addr = ad; host_wdata = wd;
    @(negedge clk);                        // accept edge N has passed
    host_valid = 1'b0;
    host_size = 2'($urandom); host_addr = 8'($urandom); host_wdata = $urandom;
    check_eq("host_ready_busy", host_ready, 32'd0);
    if (ok) begin
      check_eq("req_size", req, 32'(sz));
      check_eq("req_wnr", wnr, 32'(wr));
      check_eq("req_addr", address, 32'(ad));
      check_eq("req_data", data_in, wd);
      check_eq("rsp_early", rsp_valid, 32'd0);
      seen_req = req;
      @(negedge clk);                      // WAIT: register set answers now
      check_eq("req_one_cycle", req, 32'd0);
      check_eq("wait_addr", address, 32'(ad));
      check_eq("wait_data", data_in, wd);
      for (int i = 0; i < 4; i++) data_out[8*i +: 8] = rs_mem[(int'(address) + i) % 256];
      if (wnr) begin
        for (int i = 0; i < nbytes(int'(seen_req)); i++)
          rs_mem[(int'(address) + i) % 256] = data_in[8*i +: 8];
      end
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0; data_out = $urandom;
      check_eq("rsp_latency", rsp_valid, 32'd1);
      if (wr) begin
        for (int i = 0; i < nbytes(int'(sz)); i++) exp_mem[(int'(ad) + i) % 256] = wd[8*i +: 8];
        exp_rd = 32'd0;
      end else begin
        exp_rd = model_read(int'(sz), int'(ad));
      end
      exp_err = 32'd0;
    end else begin
      check_eq("illegal_no_req", req, 32'd0);
      check_eq("illegal_rsp", rsp_valid, 32'd1);
      exp_rd = 32'd0;
      exp_err = 32'd1;
    end
    for (int i = 0; i < hold; i++) begin
      check_eq("hold_valid", rsp_valid, 32'd1);
      check_eq("hold_rdata", rsp_rdata, exp_rd);
      check_eq("hold_ready", host_ready, 32'd0);
      check_eq("hold_req", req, 32'd0);
      @(negedge clk);
    end
    check_eq("rsp_valid", rsp_valid, 32'd1);
    check_eq("rsp_rdata", rsp_rdata, exp_rd);
    check_eq("rsp_err", rsp_err, exp_err);
    got = rsp_rdata;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("rsp_drop", rsp_valid, 32'd0);
    check_eq("ready_back", host_ready, 32'd1);
  endtask

  initial begin
    logic [31:0] got;
    for (int i = 0; i < 256; i++) begin
      exp_mem[i] = 8'($urandom);
      rs_mem[i]  = exp_mem[i];
    end
    #1 reset = 1'b0;
    #2 check_reset_values("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Directed: word write/read and sub-word reads of the same word.
    do_txn(1'b1, 2'd3, 8'h04, 32'hDEADBEEF, 0, got);
    check_eq("dir_wr_rdata", got, 32'd0);
    do_txn(1'b0, 2'd3, 8'h04, 32'h0, 0, got);
    check_eq("dir_word", got, 32'hDEADBEEF);
    do_txn(1'b0, 2'd1, 8'h05, 32'h0, 0, got);
    check_eq("dir_byte", got, 32'h000000BE);
    do_txn(1'b0, 2'd2, 8'h06, 32'h0, 5, got);
    check_eq("dir_half", got, 32'h0000DEAD);

    // Directed illegal requests.
    do_txn(1'b0, 2'd3, 8'h02, 32'h0, 0, got);
    do_txn(1'b0, 2'd2, 8'h03, 32'h0, 1, got);
    do_txn(1'b1, 2'd0, 8'h00, 32'h12345678, 0, got);

    // Stray ack while idle changes nothing.
    ack = 1'b1; data_out = $urandom;
    @(negedge clk);
    ack = 1'b0;
    check_eq("stray_ack_valid", rsp_valid, 32'd0);
    check_eq("stray_ack_ready", host_ready, 32'd1);
    check_eq("stray_ack_req", req, 32'd0);

    // Randomized traffic, including the top-of-space addresses.
    for (int t = 0; t < 60; t++) begin
      logic [7:0] ad;
      ad = (t % 3 == 0) ? 8'(8'hF8 + $urandom_range(0, 7)) : 8'($urandom);
      do_txn(1'($urandom), 2'($urandom_range(0, 3)), ad, $urandom, $urandom_range(0, 3), got);
    end

`ifdef REG_BRIDGE_TIMEOUT_EN
    begin
      int cyc;
      host_valid = 1'b1; host_wnr = 1'b0; host_size = 2'd3; host_addr = 8'h10;
      @(negedge clk);
      host_valid = 1'b0;
      cyc = 0;
      while (!rsp_valid && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      check_eq("tmo_cycles", 32'(cyc), 32'd17);
      check_eq("tmo_err", rsp_err, 32'd1);
      check_eq("tmo_rdata", rsp_rdata, 32'd0);
      ack = 1'b1; data_out = 32'hA5A5A5A5;
      @(negedge clk);
      ack = 1'b0;
      check_eq("late_ack_valid", rsp_valid, 32'd1);
      check_eq("late_ack_err", rsp_err, 32'd1);
      check_eq("late_ack_rdata", rsp_rdata, 32'd0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check_eq("tmo_ready_back", host_ready, 32'd1);
      do_txn(1'b0, 2'd3, 8'h04, 32'h0, 0, got);
      check_eq("tmo_next_word", got, model_read(3, 4));
    end
`endif

    // Reset while waiting for ack; the late ack afterwards must be ignored.
    host_valid = 1'b1; host_wnr = 1'b0; host_size = 2'd3; host_addr = 8'h04;
    @(negedge clk);
    host_valid = 1'b0;
    @(negedge clk);                        // bridge now in WAIT
    #2 reset = 1'b0;
    #1 check_reset_values("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    ack = 1'b1; data_out = $urandom;
    @(negedge clk);
    ack = 1'b0;
    check_eq("post_rst_ack_valid", rsp_valid, 32'd0);
    check_eq("post_rst_ack_ready", host_ready, 32'd1);
    check_eq("post_rst_ack_req", req, 32'd0);
    do_txn(1'b0, 2'd3, 8'h04, 32'h0, 0, got);
    check_eq("post_rst_word", got, 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
